// File: rtl/life_pkg.sv
// Shared constants and helpers for the parametrised Game-of-Life array.
// Cell vectors are column-major: cell(r,c) lives at bit c*ROWS+r.
package life_pkg;

    localparam int EDGE_DEAD = 0;
    localparam int EDGE_WRAP = 1;
    localparam int NBR_W     = 4;

    function automatic int idx(input int r, input int c, input int rows);
        return c * rows + r;
    endfunction

endpackage

// File: rtl/life_array_nxm_if.sv
// Host/readout bundle for life_array_nxm.
// The host drives the master side, the cell array implements the slave side.
interface life_array_nxm_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int GEN_W = 16
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic                 clear;
    logic                 write_enb;
    logic [RW-1:0]        row;
    logic [CW-1:0]        col;
    logic                 val;
    logic                 run;
    logic                 step;
    logic [ROWS*COLS-1:0] alive;
    logic [GEN_W-1:0]     gen_count;
    logic                 stable;
    logic                 osc2;
    logic                 extinct;

    modport master (
        output clear, write_enb, row, col, val, run, step,
        input  alive, gen_count, stable, osc2, extinct
    );

    modport slave (
        input  clear, write_enb, row, col, val, run, step,
        output alive, gen_count, stable, osc2, extinct
    );

endinterface

// File: rtl/life_cell.sv
// One Game-of-Life cell: neighbour count, survival/birth rule, state flop.
// Control priority inside the cell is clear > write > advance > hold.
module life_cell
    import life_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_wr,
    input  logic       i_val,
    input  logic       i_adv,
    input  logic [7:0] i_nbr,
    output logic       o_alive,
    output logic       o_next
);

    logic             r_alive;
    logic [NBR_W-1:0] w_cnt;

    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < 8; k++) begin
            w_cnt = w_cnt + NBR_W'(i_nbr[k]);
        end
    end

    assign o_next = (w_cnt == NBR_W'(3)) |
                    (r_alive & (w_cnt == NBR_W'(2)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alive <= 1'b0;
        end else if (i_clear) begin
            r_alive <= 1'b0;
        end else if (i_wr) begin
            r_alive <= i_val;
        end else if (i_adv) begin
            r_alive <= o_next;
        end
    end

    assign o_alive = r_alive;

endmodule

// File: rtl/life_array_nxm.sv
// ROWS x COLS Game-of-Life array with dead or toroidal edges,
// saturating generation counter and still/oscillator/extinct status.
module life_array_nxm
    import life_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int WRAP  = 0,
    parameter int GEN_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    life_array_nxm_if.slave bus
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic [N-1:0]     w_alive;
    logic [N-1:0]     w_next;
    logic [N-1:0]     w_wsel;
    logic [N-1:0]     w_after_wr;
    logic             w_row_ok;
    logic             w_col_ok;
    logic             w_wr_ok;
    logic             w_adv;

    logic [N-1:0]     r_prev;
    logic [GEN_W-1:0] r_gen;
    logic             r_stable;
    logic             r_osc2;
    logic             r_seen;

    assign w_row_ok = {1'b0, bus.row} < (RW+1)'(ROWS);
    assign w_col_ok = {1'b0, bus.col} < (CW+1)'(COLS);
    assign w_wr_ok  = bus.write_enb & ~bus.clear & w_row_ok & w_col_ok;
    // Any write request, even out of range, blocks the advance.
    assign w_adv    = (bus.run | bus.step) & ~bus.write_enb & ~bus.clear;

    for (genvar r = 0; r < ROWS; r++) begin : g_r
        for (genvar c = 0; c < COLS; c++) begin : g_c
            localparam int I = idx(r, c, ROWS);
            logic [7:0] w_nbr;

            for (genvar k = 0; k < 8; k++) begin : g_k
                localparam int DR = (k < 3) ? -1 : (k < 5) ? 0 : 1;
                localparam int DC = (k == 0 || k == 3 || k == 5) ? -1 :
                                    (k == 1 || k == 6) ? 0 : 1;
                localparam int RR = r + DR;
                localparam int CC = c + DC;
                localparam int RM = (RR + ROWS) % ROWS;
                localparam int CM = (CC + COLS) % COLS;
                localparam bit INSIDE = (RR >= 0) && (RR < ROWS) &&
                                        (CC >= 0) && (CC < COLS);
                if (WRAP == EDGE_WRAP) begin : g_wrap
                    assign w_nbr[k] = w_alive[idx(RM, CM, ROWS)];
                end else if (INSIDE) begin : g_in
                    assign w_nbr[k] = w_alive[idx(RR, CC, ROWS)];
                end else begin : g_out
                    assign w_nbr[k] = 1'b0;
                end
            end

            assign w_wsel[I] = w_wr_ok &
                               (bus.row == RW'(r)) &
                               (bus.col == CW'(c));
            assign w_after_wr[I] = w_wsel[I] ? bus.val : w_alive[I];

            life_cell u_cell (
                .i_clk   (clk),
                .i_rst_n (reset),
                .i_clear (bus.clear),
                .i_wr    (w_wsel[I]),
                .i_val   (bus.val),
                .i_adv   (w_adv),
                .i_nbr   (w_nbr),
                .o_alive (w_alive[I]),
                .o_next  (w_next[I])
            );
        end
    end

    // r_seen marks that one advance has happened since the last load,
    // so osc2 can only rise from the second advance on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev   <= '0;
            r_gen    <= '0;
            r_stable <= 1'b0;
            r_osc2   <= 1'b0;
            r_seen   <= 1'b0;
        end else if (bus.clear) begin
            r_prev   <= '0;
            r_gen    <= '0;
            r_stable <= 1'b0;
            r_osc2   <= 1'b0;
            r_seen   <= 1'b0;
        end else if (w_wr_ok) begin
            r_prev   <= w_after_wr;
            r_gen    <= '0;
            r_stable <= 1'b0;
            r_osc2   <= 1'b0;
            r_seen   <= 1'b0;
        end else if (w_adv) begin
            r_prev   <= w_alive;
            if (r_gen != '1) begin
                r_gen <= r_gen + 1'b1;
            end
            r_stable <= (w_next == w_alive);
            r_osc2   <= r_seen & (w_next == r_prev) &
                        (w_next != w_alive);
            r_seen   <= 1'b1;
        end
    end

    assign bus.alive     = w_alive;
    assign bus.gen_count = r_gen;
    assign bus.stable    = r_stable;
    assign bus.osc2      = r_osc2;
    assign bus.extinct   = ~|w_alive;

endmodule
